ovf_event_arbiter: RTL and testbench
====================================

Name: ovf_event_arbiter

Overview:
- Owns NUM_CH free-running event counters, each CNT_W bits wide.
- Detects wrap-around overflow on each counter and latches it as a pending event per channel.
- Shares a single event-report port between all channels using a round-robin arbiter with a valid/ready handshake.
- Sits between the counter datapath and the interrupt/status logic, which consumes one overflow event per handshake.

Parameters:
NUM_CH, 4, number of counter channels (2..16)
CNT_W, 8, counter width in bits
ID_W, $clog2(NUM_CH), derived localparam, width of the channel id

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state at the next rising edge of clk
en  input  1  global count enable
inc  input  NUM_CH  per-channel increment request
clr  input  NUM_CH  per-channel counter clear
count  output  NUM_CH*CNT_W  counter values, channel i at bits [i*CNT_W +: CNT_W]
evt_valid  output  1  overflow event presented
evt_ready  input  1  consumer accepts the event
evt_id  output  ID_W  channel of the presented event
evt_lost  output  1  sticky: an overflow was dropped
lost_clr  input  1  clears evt_lost

Behaviour:
- Reset values: all counts 0, pending 0, evt_valid 0, evt_id 0, round-robin pointer 0, evt_lost 0, FSM in IDLE.
- Reset mid-operation discards pending events and any presented event.
- Counter i update each cycle:
  - clr[i]=1: count becomes 0, independent of en and inc[i]. Pending[i] is unaffected.
  - else en=1 and inc[i]=1: count increments by 1.
  - else: count holds.
- Overflow: an increment with count == all-ones wraps the count to 0 and sets pending[i] on the same edge.
- Loss: if pending[i] is already 1 when a new overflow on i occurs, pending stays 1 and evt_lost is set.
- Overflow on the channel currently presented: its pending bit was already cleared at grant, so it sets pending again and does not count as lost.
- Arbiter FSM, 2 states:
  - IDLE: evt_valid=0. If any pending bit is set, grant the first set index searching from ptr upward with wrap. On that edge: evt_id <= index, pending[index] cleared, evt_valid <= 1, go to PRESENT.
  - PRESENT: evt_valid=1 and evt_id held stable until evt_valid && evt_ready.
  - On handshake: ptr <= (evt_id+1) mod NUM_CH.
  - On handshake, if another pending bit is set (searched from the new ptr), grant it on the same edge. evt_valid stays 1, giving one event per cycle back-to-back. Otherwise go to IDLE and evt_valid <= 0.
- Grant and new overflow on the same channel, same edge: set wins, pending stays 1, not lost.
- Latency: an overflow at edge k gives evt_valid=1 after edge k+1 when the FSM was IDLE.
- Arbitration uses pending values registered before the edge, so same-edge overflows become visible next cycle.
- lost_clr=1 clears evt_lost. A loss on the same edge wins and evt_lost stays 1.
- en=0 freezes the counters only; arbitration and the handshake continue.

Optional Feature:
OVF_SATURATE_EN
- Defined: counters saturate at all-ones instead of wrapping.
  - The event (pending set) fires on the increment from all-ones-1 to all-ones.
  - Further increments at all-ones are ignored and raise no event and no loss.
  - clr is the only way to leave saturation.
- Undefined: wrap-around behaviour as described in Behaviour.

Test Plan:
- Reset held with inc=4'hF and en=1 -> all counts 0, evt_valid 0, evt_lost 0 after release.
- Ch1 pre-counted to 8'hFF, pulse inc[1] with evt_ready=0 -> count[1]=0 and pending set; evt_valid=1 and evt_id=1 one cycle later; both held until evt_ready=1.
- Ch0, ch2, ch3 overflow on the same edge, evt_ready=1 -> ids 0,2,3 on consecutive cycles. Then ch0 and ch2 overflow together after ptr=0 (from the id 3 handshake) -> order 0,2. Round-robin is confirmed by preferring ch2 over ch0 once ptr=1.
- Ch2 overflows twice while unserved, evt_ready=0 -> evt_lost=1; lost_clr pulse -> 0. lost_clr on the same cycle as a third loss -> stays 1.
- en=0 with inc=4'hF for 10 cycles -> counts unchanged. clr[3]=1 with inc[3]=1 at 8'hFF -> count[3]=0 and no event.
- OVF_SATURATE_EN defined, inc[0] from 8'hFD for 5 cycles -> count[0] sticks at 8'hFF and exactly one event with id 0 is raised; no evt_lost.

Source files
------------

// File: rtl/ovf_event_arbiter.sv
// Per-channel event counters with overflow detection and a round-robin event-report port.
// Optional OVF_SATURATE_EN: counters saturate at all-ones and report on reaching it.
module ovf_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  localparam int ID_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [ID_W-1:0]         evt_id,
  output logic                    evt_lost,
  input  logic                    lost_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PEN = CNT_MAX - CNT_W'(1);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state_reg, state_next;
  logic [NUM_CH-1:0] pending_reg, pending_next;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] grant_mask;
  logic [ID_W-1:0]   evt_id_reg, evt_id_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic              evt_lost_reg, evt_lost_next;
  logic              lost_hit;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             step;

      assign step = en && inc[gi] && !clr[gi];

`ifdef OVF_SATURATE_EN
      // Event fires on reaching all-ones; increments at all-ones are dropped.
      assign ovf[gi] = step && (cnt_reg == CNT_PEN);
      always_comb begin
        cnt_next = cnt_reg;
        if (clr[gi])
          cnt_next = '0;
        else if (step && (cnt_reg != CNT_MAX))
          cnt_next = cnt_reg + CNT_W'(1);
      end
`else
      assign ovf[gi] = step && (cnt_reg == CNT_MAX);
      always_comb begin
        cnt_next = cnt_reg;
        if (clr[gi])
          cnt_next = '0;
        else if (step)
          cnt_next = cnt_reg + CNT_W'(1);
      end
`endif

      always_ff @(posedge clk) begin
        if (reset)
          cnt_reg <= '0;
        else
          cnt_reg <= cnt_next;
      end

      assign count[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  // Search base: after a handshake the pointer moves past the served channel.
  logic [ID_W-1:0] id_plus1;
  logic [ID_W-1:0] base;
  assign id_plus1 = (evt_id_reg == ID_W'(NUM_CH - 1)) ? '0 : evt_id_reg + ID_W'(1);
  assign base     = (state_reg == PRESENT) ? id_plus1 : ptr_reg;

  logic            found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, base} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_CH))
        sum = sum - (ID_W+1)'(NUM_CH);
      idx = sum[ID_W-1:0];
      if (!found && pending_reg[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    evt_id_next = evt_id_reg;
    ptr_next    = ptr_reg;
    grant_mask  = '0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_mask  = NUM_CH'(1) << grant_idx;
          evt_id_next = grant_idx;
          state_next  = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          ptr_next = id_plus1;
          if (found) begin
            grant_mask  = NUM_CH'(1) << grant_idx;
            evt_id_next = grant_idx;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // New overflows win over the grant clear; only an already-waiting event is lost.
  always_comb begin
    pending_next  = (pending_reg & ~grant_mask) | ovf;
    lost_hit      = |(ovf & pending_reg & ~grant_mask);
    evt_lost_next = evt_lost_reg;
    if (lost_hit)
      evt_lost_next = 1'b1;
    else if (lost_clr)
      evt_lost_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      evt_id_reg   <= '0;
      ptr_reg      <= '0;
      evt_lost_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      evt_id_reg   <= evt_id_next;
      ptr_reg      <= ptr_next;
      evt_lost_reg <= evt_lost_next;
    end
  end

  assign evt_valid = (state_reg == PRESENT);
  assign evt_id    = evt_id_reg;
  assign evt_lost  = evt_lost_reg;

endmodule

// File: tb/tb_ovf_event_arbiter.sv
// Scenario bench for ovf_event_arbiter; presented events are checked against a queue of expected ids.
module tb_ovf_event_arbiter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
`ifdef OVF_SATURATE_EN
  localparam int         PRE   = 254;
  localparam logic [7:0] AFTER = 8'hFF;
`else
  localparam int         PRE   = 255;
  localparam logic [7:0] AFTER = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [3:0]  inc = 4'h0;
  logic [3:0]  clr = 4'h0;
  logic [31:0] count;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [1:0]  evt_id;
  logic        evt_lost;
  logic        lost_clr = 1'b0;

  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];

  ovf_event_arbiter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .clr(clr), .count(count),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_lost(evt_lost), .lost_clr(lost_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  // Inputs change 1 time unit after posedge, so negedge sees what the next edge will see.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      logic [1:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL evt_unexpected: got id=%0d want no event", evt_id);
      end else begin
        e = exp_q.pop_front();
        $display("evt handshake id=%0d expected=%0d", evt_id, e);
        if (evt_id !== e) begin
          bad++;
          $display("FAIL evt_order: got id=%0d want %0d", evt_id, e);
        end
      end
    end
  end

  function automatic logic [7:0] cnt(input int i);
    return count[i*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] mask);
    clr = mask; inc = 4'h0; tick(); clr = 4'h0;
    inc = mask; repeat (PRE) tick(); inc = 4'h0;
  endtask

  task automatic fire(input logic [3:0] mask);
    inc = mask; tick(); inc = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; inc = 4'hF;
    repeat (3) tick();
    reset = 1'b0; inc = 4'h0;
    total++;
    if (count !== 32'h0) begin bad++; $display("FAIL reset_count: got %h want 0", count); end
    total++;
    if (evt_valid !== 1'b0 || evt_lost !== 1'b0 || evt_id !== 2'd0) begin
      bad++; $display("FAIL reset_flags: got valid=%b lost=%b id=%0d want 0 0 0", evt_valid, evt_lost, evt_id);
    end
  endtask

  task automatic test_single();
    evt_ready = 1'b0;
    preload(4'b0010);
    exp_q.push_back(2'd1);
    fire(4'b0010);
    total++;
    if (cnt(1) !== AFTER || evt_valid !== 1'b0) begin
      bad++; $display("FAIL single_wrap: got cnt=%h valid=%b want %h 0", cnt(1), evt_valid, AFTER);
    end
    tick();
    total++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      bad++; $display("FAIL single_present: got valid=%b id=%0d want 1 1", evt_valid, evt_id);
    end
    repeat (3) tick();
    total++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      bad++; $display("FAIL single_hold: got valid=%b id=%0d want 1 1", evt_valid, evt_id);
    end
    evt_ready = 1'b1;
    tick();
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got valid=%b want 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] ids [3];
    ids[0] = 2'd0; ids[1] = 2'd2; ids[2] = 2'd3;
    do_reset();
    evt_ready = 1'b1;
    preload(4'b1101);
    for (int i = 0; i < 3; i++) exp_q.push_back(ids[i]);
    fire(4'b1101);
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL b2b_latency: got valid=%b want 0", evt_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (evt_valid !== 1'b1 || evt_id !== ids[i]) begin
        bad++; $display("FAIL b2b_slot%0d: got valid=%b id=%0d want 1 %0d", i, evt_valid, evt_id, ids[i]);
      end
    end
    tick();
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got valid=%b want 0", evt_valid); end
    // ptr is 0 after serving id 3
    preload(4'b0101);
    exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    fire(4'b0101);
    tick();
    total++;
    if (evt_id !== 2'd0) begin bad++; $display("FAIL pair_first: got id=%0d want 0", evt_id); end
    tick();
    total++;
    if (evt_id !== 2'd2) begin bad++; $display("FAIL pair_second: got id=%0d want 2", evt_id); end
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    evt_ready = 1'b0;
    preload(4'b0001);
    exp_q.push_back(2'd0);
    fire(4'b0001);
    tick();
    preload(4'b0101);
    exp_q.push_back(2'd2); exp_q.push_back(2'd0);
    fire(4'b0101);
    total++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_lost !== 1'b0) begin
      bad++; $display("FAIL rr_presented_reovf: got valid=%b id=%0d lost=%b want 1 0 0", evt_valid, evt_id, evt_lost);
    end
    evt_ready = 1'b1;
    tick();
    total++;
    if (evt_id !== 2'd2) begin bad++; $display("FAIL rr_prefer_ch2: got id=%0d want 2", evt_id); end
    tick();
    total++;
    if (evt_id !== 2'd0 || evt_valid !== 1'b1) begin
      bad++; $display("FAIL rr_then_ch0: got valid=%b id=%0d want 1 0", evt_valid, evt_id);
    end
    tick();
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL rr_idle: got valid=%b want 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

`ifndef OVF_SATURATE_EN
  task automatic test_loss();
    evt_ready = 1'b0;
    preload(4'b0100); exp_q.push_back(2'd2); fire(4'b0100);
    tick();
    preload(4'b0100); exp_q.push_back(2'd2); fire(4'b0100);
    total++;
    if (evt_lost !== 1'b0) begin bad++; $display("FAIL loss_second: got lost=%b want 0", evt_lost); end
    preload(4'b0100); fire(4'b0100);
    total++;
    if (evt_lost !== 1'b1) begin bad++; $display("FAIL loss_third: got lost=%b want 1", evt_lost); end
    lost_clr = 1'b1; tick(); lost_clr = 1'b0;
    total++;
    if (evt_lost !== 1'b0) begin bad++; $display("FAIL loss_clear: got lost=%b want 0", evt_lost); end
    preload(4'b0100);
    lost_clr = 1'b1; fire(4'b0100); lost_clr = 1'b0;
    total++;
    if (evt_lost !== 1'b1) begin bad++; $display("FAIL loss_vs_clear: got lost=%b want 1", evt_lost); end
    evt_ready = 1'b1;
    tick();
    total++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
      bad++; $display("FAIL loss_drain: got valid=%b id=%0d want 1 2", evt_valid, evt_id);
    end
    tick();
    evt_ready = 1'b0;
    lost_clr = 1'b1; tick(); lost_clr = 1'b0;
  endtask
`else
  task automatic test_saturate();
    do_reset();
    evt_ready = 1'b1;
    clr = 4'b0001; tick(); clr = 4'h0;
    inc = 4'b0001; repeat (253) tick();
    exp_q.push_back(2'd0);
    repeat (5) tick();
    inc = 4'h0;
    repeat (3) tick();
    total++;
    if (cnt(0) !== 8'hFF) begin bad++; $display("FAIL sat_stick: got %h want ff", cnt(0)); end
    total++;
    if (evt_lost !== 1'b0 || evt_valid !== 1'b0) begin
      bad++; $display("FAIL sat_flags: got lost=%b valid=%b want 0 0", evt_lost, evt_valid);
    end
    evt_ready = 1'b0;
  endtask
`endif

  task automatic test_enable();
    do_reset();
    preload(4'b1000);
    en = 1'b0; inc = 4'hF;
    repeat (10) tick();
    inc = 4'h0; en = 1'b1;
    total++;
    if (count !== {PRE[7:0], 24'h0}) begin
      bad++; $display("FAIL en_freeze: got %h want %h", count, {PRE[7:0], 24'h0});
    end
    clr = 4'b1000; inc = 4'b1000; tick(); clr = 4'h0; inc = 4'h0;
    total++;
    if (cnt(3) !== 8'h00) begin bad++; $display("FAIL clr_priority: got %h want 00", cnt(3)); end
    repeat (2) tick();
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL clr_no_event: got valid=%b want 0", evt_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
`ifndef OVF_SATURATE_EN
    test_loss();
`else
    test_saturate();
`endif
    test_enable();
    repeat (2) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL queue_drained: got %0d outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
